// File: rtl/udp_payload_reader_if.sv
// Byte-stream handshake between the payload reader and the UDP/IP framer.
// master drives data/valid/last/pad, slave returns ready.
interface udp_payload_reader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic       byte_pad;

  modport master (
    output byte_data,
    output byte_valid,
    output byte_last,
    output byte_pad,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_last,
    input  byte_pad,
    output byte_ready
  );
endinterface

// File: rtl/udp_payload_reader.sv
// UDP payload RAM read side: fetches 32-bit words and streams them as
// MSB-first bytes, zero-padding short payloads up to MIN_PAYLOAD bytes.
module udp_payload_reader #(
  parameter int ADDR_W      = 9,
  parameter int START_ADDR  = 1,
  parameter int MIN_PAYLOAD = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       data_length,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  udp_payload_reader_if.master tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(START_ADDR);
  localparam logic [15:0]       MIN_LEN = 16'(MIN_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM,
    PAD,
    FIN
  } state_t;

  state_t      state;
  logic [15:0] pay_len;
  logic [15:0] tot_len;
  logic [15:0] rem_pay;
  logic [15:0] rem_tot;
  logic [23:0] shreg;
  logic [1:0]  bidx;
  logic        xfer;

  always_comb begin
    pay_len = 16'd0;
    if (data_length >= 16'd8)
      pay_len = data_length - 16'd8;
    tot_len = (pay_len > MIN_LEN) ? pay_len : MIN_LEN;
  end

  assign xfer = tx.byte_valid & tx.byte_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      ram_rd_addr   <= BASE;
      tx.byte_data  <= 8'h00;
      tx.byte_valid <= 1'b0;
      tx.byte_last  <= 1'b0;
      tx.byte_pad   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rem_pay       <= 16'd0;
      rem_tot       <= 16'd0;
      shreg         <= 24'd0;
      bidx          <= 2'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem_pay     <= pay_len;
            rem_tot     <= tot_len;
            ram_rd_addr <= BASE;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          if (rem_pay != 16'd0) begin
            tx.byte_data  <= ram_rd_data[31:24];
            shreg         <= ram_rd_data[23:0];
            bidx          <= 2'd0;
            ram_rd_addr   <= ram_rd_addr + ADDR_W'(1);
            tx.byte_valid <= 1'b1;
            tx.byte_last  <= (rem_tot == 16'd1);
            state         <= STREAM;
          end else if (rem_tot != 16'd0) begin
            tx.byte_data  <= 8'h00;
            tx.byte_pad   <= 1'b1;
            tx.byte_valid <= 1'b1;
            tx.byte_last  <= (rem_tot == 16'd1);
            state         <= PAD;
          end else begin
            done        <= 1'b1;
            busy        <= 1'b0;
            ram_rd_addr <= BASE;
            state       <= FIN;
          end
        end
        STREAM: begin
          if (xfer) begin
            rem_pay <= rem_pay - 16'd1;
            rem_tot <= rem_tot - 16'd1;
            if (rem_pay > 16'd1) begin
              tx.byte_last <= (rem_tot == 16'd2);
              // next word has been on ram_rd_data since the last increment
              if (bidx == 2'd3) begin
                tx.byte_data <= ram_rd_data[31:24];
                shreg        <= ram_rd_data[23:0];
                bidx         <= 2'd0;
                ram_rd_addr  <= ram_rd_addr + ADDR_W'(1);
              end else begin
                tx.byte_data <= shreg[23:16];
                shreg        <= {shreg[15:0], 8'h00};
                bidx         <= bidx + 2'd1;
              end
            end else if (rem_tot > 16'd1) begin
              tx.byte_data <= 8'h00;
              tx.byte_pad  <= 1'b1;
              tx.byte_last <= (rem_tot == 16'd2);
              state        <= PAD;
            end else begin
              tx.byte_valid <= 1'b0;
              tx.byte_last  <= 1'b0;
              done          <= 1'b1;
              busy          <= 1'b0;
              ram_rd_addr   <= BASE;
              state         <= FIN;
            end
          end
        end
        PAD: begin
          if (xfer) begin
            rem_tot <= rem_tot - 16'd1;
            if (rem_tot > 16'd1) begin
              tx.byte_last <= (rem_tot == 16'd2);
            end else begin
              tx.byte_valid <= 1'b0;
              tx.byte_last  <= 1'b0;
              tx.byte_pad   <= 1'b0;
              done          <= 1'b1;
              busy          <= 1'b0;
              ram_rd_addr   <= BASE;
              state         <= FIN;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
